// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared constants and types for the ALU-side iterative divider.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = DIV_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One restoring-division iteration: shift {rem, quo} left,
//               trial-subtract the divisor, keep or restore the remainder.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;
  logic           w_ok;

  // Trial subtraction at WIDTH+1 bits: rem < divisor holds between steps, so
  // the shifted remainder is below 2*divisor and the top bit is a valid sign.
  always_comb begin
    w_shift = {rem, quo[WIDTH-1]};
    w_trial = w_shift - {1'b0, divisor};
    w_ok    = ~w_trial[WIDTH];
    rem_nxt = w_ok ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], w_ok};
  end

endmodule
`default_nettype wire

// File: rtl/iter_divider.sv
`default_nettype none
// ============================================================================
// Module      : iter_divider
// Description : Multi-cycle restoring divider for DIV/DIVU. Works on operand
//               magnitudes and fixes the result signs on completion.
//               Quotient goes to LO, remainder to HI.
// Revision    : 1.0 - initial release
// ============================================================================
module iter_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             Sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0]    C_IDLE = IDLE;
  localparam logic [1:0]    C_CALC = CALC;
  localparam logic [1:0]    C_DONE = DONE;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_a_raw;
  logic             r_sign;
  logic             r_sa;
  logic             r_sb;
  logic             r_bzero;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dz;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_q_final;
  logic [WIDTH-1:0] w_r_final;

  // Operand magnitudes (only for signed operations) and final result fix-up;
  // the most-negative / -1 case needs nothing special since its magnitude
  // quotient already equals the most-negative pattern.
  always_comb begin
    w_a_mag   = (Sign && A[WIDTH-1]) ? (~A + 1'b1) : A;
    w_b_mag   = (Sign && B[WIDTH-1]) ? (~B + 1'b1) : B;
    w_q_final = (r_sign && (r_sa ^ r_sb)) ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
    w_r_final = (r_sign && r_sa) ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
    if (r_bzero) begin
      w_q_final = '1;
      w_r_final = r_a_raw;
    end
  end

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem     (r_rem),
    .quo     (r_quo),
    .divisor (r_div),
    .rem_nxt (w_rem_nxt),
    .quo_nxt (w_quo_nxt)
  );

  // Control FSM: capture in IDLE, WIDTH steps in CALC, one-cycle done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= C_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_a_raw     <= '0;
      r_sign      <= 1'b0;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_bzero     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dz        <= 1'b0;
    end else begin
      case (r_state)
        C_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_sign  <= Sign;
            r_sa    <= A[WIDTH-1];
            r_sb    <= B[WIDTH-1];
            r_a_raw <= A;
            r_bzero <= (B == '0);
            r_quo   <= w_a_mag;
            r_div   <= w_b_mag;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= C_CALC;
          end
        end
        C_CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == C_LAST) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_quotient  <= w_q_final;
            r_remainder <= w_r_final;
            r_dz        <= r_bzero;
            r_state     <= C_DONE;
          end
        end
        C_DONE: begin
          r_done  <= 1'b0;
          r_state <= C_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= C_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign dz        = r_dz;

endmodule
`default_nettype wire
